// File: rtl/switch_pkg.sv
// Shared types and helpers for the crossbar scheduler: destination field
// extraction, head-word classification and select encoding.
package switch_pkg;

  localparam int unsigned SEL_NONE = 0;

  typedef enum logic [1:0] {
    WORD_IDLE,
    WORD_ROUTE,
    WORD_DISCARD
  } word_kind_e;

  function automatic int unsigned calc_dest_w(input int unsigned num_ports);
    return $clog2(num_ports + 1);
  endfunction

  function automatic int unsigned extract_dest(input logic [63:0] word,
                                               input int unsigned dest_w);
    logic [63:0] mask;
    mask = (64'd1 << dest_w) - 64'd1;
    return 32'(word & mask);
  endfunction

  // Empty or already-popping heads are ignored; out-of-range dests are dropped.
  function automatic word_kind_e classify(input logic        empty,
                                          input logic        in_flight,
                                          input int unsigned dest,
                                          input int unsigned num_ports);
    if (empty || in_flight) begin
      return WORD_IDLE;
    end else if (dest == 0 || dest > num_ports) begin
      return WORD_DISCARD;
    end
    return WORD_ROUTE;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or above ptr_i,
// wrapping modulo N, receives a one-hot grant.
module rr_arbiter #(
  parameter int unsigned N  = 4,
  parameter int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  grant_o
);

  logic          found;
  logic [PW-1:0] idx;

  always_comb begin
    grant_o = '0;
    found   = 1'b0;
    idx     = '0;
    for (int unsigned off = 0; off < N; off++) begin
      idx = PW'((32'(ptr_i) + off) % N);
      if (!found && req_i[idx]) begin
        grant_o[idx] = 1'b1;
        found        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/crossbar_scheduler.sv
// Input-FIFO crossbar scheduler: per-output round-robin arbitration of FIFO
// head words, discard of unroutable words, fully registered grant outputs.
module crossbar_scheduler
  import switch_pkg::*;
#(
  parameter int unsigned NUM_PORTS = 4,
  parameter int unsigned DATA_W    = 8,
  localparam int unsigned DEST_W   = calc_dest_w(NUM_PORTS),
  localparam int unsigned SEL_W    = DEST_W
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_PORTS*DATA_W-1:0] in_data,
  input  logic [NUM_PORTS-1:0]        in_empty,
  input  logic [NUM_PORTS-1:0]        out_ready,
  output logic [NUM_PORTS-1:0]        rdreq,
  output logic [NUM_PORTS-1:0]        out_en,
  output logic [NUM_PORTS*SEL_W-1:0]  out_sel,
  output logic [15:0]                 drop_count
);

  localparam int unsigned PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  logic [NUM_PORTS-1:0]       rdreq_q, rdreq_d;
  logic [NUM_PORTS-1:0]       out_en_q, out_en_d;
  logic [NUM_PORTS*SEL_W-1:0] out_sel_q, out_sel_d;
  logic [15:0]                drop_q, drop_d;
  logic [PTR_W-1:0]           rr_ptr_q [NUM_PORTS];
  logic [PTR_W-1:0]           rr_ptr_d [NUM_PORTS];

  int unsigned                dest     [NUM_PORTS];
  word_kind_e                 kind     [NUM_PORTS];
  logic [NUM_PORTS-1:0]       discard;
  logic [NUM_PORTS-1:0]       req      [NUM_PORTS];
  logic [NUM_PORTS-1:0]       gnt      [NUM_PORTS];
  logic [16:0]                drop_sum;

  // rdreq_q doubles as the in-flight mask so a head is never granted twice.
  always_comb begin
    discard = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      dest[i]    = extract_dest(64'(in_data[i*DATA_W +: DATA_W]), DEST_W);
      kind[i]    = classify(in_empty[i], rdreq_q[i], dest[i], NUM_PORTS);
      discard[i] = (kind[i] == WORD_DISCARD);
    end
    for (int unsigned j = 0; j < NUM_PORTS; j++) begin
      req[j] = '0;
      for (int unsigned i = 0; i < NUM_PORTS; i++) begin
        req[j][i] = out_ready[j] && (kind[i] == WORD_ROUTE) && (dest[i] == j + 1);
      end
    end
  end

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_arb
    rr_arbiter #(
      .N  (NUM_PORTS),
      .PW (PTR_W)
    ) u_arb (
      .req_i   (req[g]),
      .ptr_i   (rr_ptr_q[g]),
      .grant_o (gnt[g])
    );
  end

  always_comb begin
    rdreq_d   = discard;
    out_en_d  = '0;
    out_sel_d = '0;
    rr_ptr_d  = rr_ptr_q;
    for (int unsigned j = 0; j < NUM_PORTS; j++) begin
      out_sel_d[j*SEL_W +: SEL_W] = SEL_W'(SEL_NONE);
      for (int unsigned i = 0; i < NUM_PORTS; i++) begin
        if (gnt[j][i]) begin
          out_en_d[j]                 = 1'b1;
          out_sel_d[j*SEL_W +: SEL_W] = SEL_W'(i + 1);
          rr_ptr_d[j]                 = PTR_W'((i + 1) % NUM_PORTS);
          rdreq_d[i]                  = 1'b1;
        end
      end
    end
    drop_sum = {1'b0, drop_q};
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      drop_sum = drop_sum + 17'(discard[i]);
    end
    drop_d = drop_sum[16] ? '1 : drop_sum[15:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rdreq_q   <= '0;
      out_en_q  <= '0;
      out_sel_q <= '0;
      drop_q    <= '0;
      for (int unsigned j = 0; j < NUM_PORTS; j++) begin
        rr_ptr_q[j] <= '0;
      end
    end else begin
      rdreq_q   <= rdreq_d;
      out_en_q  <= out_en_d;
      out_sel_q <= out_sel_d;
      drop_q    <= drop_d;
      rr_ptr_q  <= rr_ptr_d;
    end
  end

  assign rdreq      = rdreq_q;
  assign out_en     = out_en_q;
  assign out_sel    = out_sel_q;
  assign drop_count = drop_q;

endmodule

// File: tb/tb_crossbar_scheduler.sv
// Scoreboard bench for crossbar_scheduler: bench-side FIFOs feed the DUT, a
// reference model predicts each cycle's registered outputs into a queue.
module tb_crossbar_scheduler;

  localparam int NP = 4;
  localparam int DW = 8;
  localparam int SW = 3;

  logic             clk = 1'b0;
  logic             reset;
  logic [NP*DW-1:0] in_data;
  logic [NP-1:0]    in_empty;
  logic [NP-1:0]    out_ready;
  logic [NP-1:0]    rdreq;
  logic [NP-1:0]    out_en;
  logic [NP*SW-1:0] out_sel;
  logic [15:0]      drop_count;

  always #5 clk = ~clk;

  crossbar_scheduler #(
    .NUM_PORTS (NP),
    .DATA_W    (DW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_data    (in_data),
    .in_empty   (in_empty),
    .out_ready  (out_ready),
    .rdreq      (rdreq),
    .out_en     (out_en),
    .out_sel    (out_sel),
    .drop_count (drop_count)
  );

  typedef struct {
    logic [NP-1:0]    rdreq;
    logic [NP-1:0]    en;
    logic [NP*SW-1:0] sel;
    logic [15:0]      drop;
  } exp_t;

  exp_t       sbq[$];
  int         compared   = 0;
  int         mismatched = 0;
  logic [7:0] fq[NP][$];

  // Reference model state
  int m_ptr [NP];
  bit m_infl[NP];
  bit m_pend[NP];
  int m_drop;
  int fill_mode;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      if (mismatched <= 20)
        $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [7:0] mk(input int d);
    logic [4:0] hi;
    hi = 5'($urandom);
    return {hi, 3'(d)};
  endfunction

  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      check("rdreq",      32'(rdreq),      32'(e.rdreq));
      check("out_en",     32'(out_en),     32'(e.en));
      check("out_sel",    32'(out_sel),    32'(e.sel));
      check("drop_count", 32'(drop_count), 32'(e.drop));
    end
  end

  task automatic step(input bit rst, input logic [NP-1:0] rdy);
    exp_t e;
    bit   elig [NP];
    int   d    [NP];
    int   n;
    bit   got;
    int   i;
    @(negedge clk);
    // rdreq seen during the previous cycle pops its FIFO at the edge just passed
    for (int k = 0; k < NP; k++)
      if (m_pend[k] && fq[k].size() > 0) void'(fq[k].pop_front());
    m_pend = m_infl;
    for (int k = 0; k < NP; k++) begin
      if (fill_mode == 1) begin
        if (fq[k].size() < 6 && $urandom_range(0, 1) == 1) fq[k].push_back(8'($urandom));
      end else if (fill_mode == 2) begin
        while (fq[k].size() < 2) fq[k].push_back(8'($urandom) & 8'hF8);
      end
    end
    for (int k = 0; k < NP; k++) begin
      in_empty[k] = (fq[k].size() == 0);
      in_data[k*DW +: DW] = in_empty[k] ? 8'($urandom) : fq[k][0];
    end
    reset     = rst;
    out_ready = rdy;

    e.rdreq = '0;
    e.en    = '0;
    e.sel   = '0;
    if (rst) begin
      m_drop = 0;
      for (int k = 0; k < NP; k++) begin
        m_ptr[k]  = 0;
        m_infl[k] = 1'b0;
      end
    end else begin
      n = 0;
      for (int k = 0; k < NP; k++) begin
        elig[k] = !in_empty[k] && !m_infl[k];
        d[k]    = int'(in_data[k*DW +: DW]) % 8;
        if (elig[k] && (d[k] == 0 || d[k] > NP)) begin
          e.rdreq[k] = 1'b1;
          n++;
        end
      end
      for (int j = 0; j < NP; j++) begin
        got = 1'b0;
        if (rdy[j]) begin
          for (int k = 0; k < NP; k++) begin
            i = (m_ptr[j] + k) % NP;
            if (!got && elig[i] && d[i] == j + 1) begin
              got = 1'b1;
              e.en[j]          = 1'b1;
              e.sel[j*SW +: SW] = 3'(i + 1);
              e.rdreq[i]       = 1'b1;
              m_ptr[j]         = (i + 1) % NP;
            end
          end
        end
      end
      m_drop = (m_drop + n > 65535) ? 65535 : m_drop + n;
      for (int k = 0; k < NP; k++) m_infl[k] = e.rdreq[k];
    end
    e.drop = 16'(m_drop);
    sbq.push_back(e);
  endtask

  initial begin
    reset     = 1'b1;
    in_empty  = '1;
    out_ready = '1;
    in_data   = '0;
    fill_mode = 0;
    m_drop    = 0;
    for (int k = 0; k < NP; k++) begin
      m_ptr[k]  = 0;
      m_infl[k] = 1'b0;
      m_pend[k] = 1'b0;
      repeat (2) fq[k].push_back(mk($urandom_range(1, 4)));
    end

    // Reset with non-empty FIFOs, then grants start on release
    repeat (3) step(1'b1, 4'hF);
    repeat (20) step(1'b0, 4'hF);

    // Three inputs competing for output 0
    for (int k = 0; k < 3; k++) repeat (4) fq[k].push_back(mk(1));
    repeat (20) step(1'b0, 4'hF);

    // Dest-0 words on input 3 are dropped
    repeat (3) fq[3].push_back(mk(0));
    repeat (10) step(1'b0, 4'hF);

    // Back-pressure on output 2 holds input 1
    fq[1].push_back(mk(3));
    repeat (4) step(1'b0, 4'b1011);
    repeat (4) step(1'b0, 4'hF);

    // All four outputs granted in one cycle
    fq[0].push_back(mk(4));
    fq[1].push_back(mk(3));
    fq[2].push_back(mk(2));
    fq[3].push_back(mk(1));
    repeat (4) step(1'b0, 4'hF);

    // Random traffic with occasional reset
    fill_mode = 1;
    repeat (3000) step($urandom_range(0, 199) == 0, 4'($urandom));

    // Flood of discards drives drop_count into saturation
    fill_mode = 0;
    repeat (2) step(1'b1, 4'hF);
    fill_mode = 2;
    repeat (33000) step(1'b0, 4'hF);

    // Reset in the middle of live grants
    fill_mode = 1;
    repeat (6) step(1'b0, 4'hF);
    step(1'b1, 4'hF);
    repeat (6) step(1'b0, 4'hF);

    fill_mode = 0;
    repeat (3) @(posedge clk);
    #2;
    check("scoreboard_drain", 32'(sbq.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
